// File: rtl/draw_sprite_pipe_if.sv
// VGA timing and colour bundle passed between draw stages.
interface vga_if;
    logic [11:0] vcount;
    logic [11:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport src (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport snk (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_sprite_pipe.sv
// ROM-backed sprite overlay with tear-free position updates at vertical blank.
// rom_pixel is sampled ROM_LAT clock edges after the edge that launched rom_addr.
module draw_sprite_pipe #(
    parameter int unsigned W         = 100,
    parameter int unsigned H         = 100,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned ROM_LAT   = 1,
    parameter bit          KEY_EN    = 1'b1,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.snk                vga_in,
    vga_if.src                vga_out,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic              mirror_x,
    input  logic              sprite_en,
    input  logic              pos_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_pixel,
    output logic              frame_upd
);
    localparam int unsigned DLY = ROM_LAT;

    typedef struct packed {
        logic [11:0] vcount;
        logic [11:0] hcount;
        logic        vsync;
        logic        hsync;
        logic        vblnk;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef struct packed {
        vga_t vga;
        logic hit;
    } stage_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        mirror;
        logic        en;
    } pos_t;

    pos_t              pos_in;
    pos_t              pend_q, pend_d;
    pos_t              act_q, act_d;
    logic              pend_vld_q, pend_vld_d;
    logic              vblnk_prev_q, vblnk_prev_d;
    logic              frame_upd_q, frame_upd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    stage_t            pipe_q [DLY];
    stage_t            pipe_d [DLY];
    vga_t              out_q, out_d;

    logic              vblnk_rise;
    logic [12:0]       h13, v13, x_hi, y_hi;
    logic              hit;
    logic [11:0]       col_raw, row_raw, col;
    stage_t            tail;
    logic              keyed;
    logic              show;

    assign pos_in = {xpos, ypos, mirror_x, sprite_en};

    always_comb begin
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        act_d        = act_q;
        frame_upd_d  = 1'b0;
        vblnk_prev_d = vga_in.vblnk;
        vblnk_rise   = vga_in.vblnk & ~vblnk_prev_q;
        // A strobe landing on the blanking edge bypasses the pending copy.
        if (vblnk_rise && (pos_valid || pend_vld_q)) begin
            act_d       = pos_valid ? pos_in : pend_q;
            pend_vld_d  = 1'b0;
            frame_upd_d = 1'b1;
        end else if (pos_valid) begin
            pend_d     = pos_in;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        h13  = {1'b0, vga_in.hcount};
        v13  = {1'b0, vga_in.vcount};
        x_hi = {1'b0, act_q.x} + 13'(W);
        y_hi = {1'b0, act_q.y} + 13'(H);
        hit  = act_q.en
            && (h13 >= {1'b0, act_q.x}) && (h13 < x_hi)
            && (v13 >= {1'b0, act_q.y}) && (v13 < y_hi);
        col_raw = vga_in.hcount - act_q.x;
        row_raw = vga_in.vcount - act_q.y;
        col     = act_q.mirror ? 12'(W - 1) - col_raw : col_raw;
        rom_addr_d = hit
            ? ADDR_W'(row_raw) * ADDR_W'(W) + ADDR_W'(col)
            : '0;
    end

    always_comb begin
        pipe_d[0].vga = {vga_in.vcount, vga_in.hcount,
                         vga_in.vsync, vga_in.hsync,
                         vga_in.vblnk, vga_in.hblnk, vga_in.rgb};
        pipe_d[0].hit = hit;
        for (int i = 1; i < int'(DLY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        tail  = pipe_q[DLY-1];
        keyed = KEY_EN && (rom_pixel == KEY_COLOR);
        show  = tail.hit && !keyed && !(tail.vga.hblnk || tail.vga.vblnk);
        out_d = tail.vga;
        if (show) begin
            out_d.rgb = rom_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            act_q        <= '0;
            vblnk_prev_q <= 1'b0;
            frame_upd_q  <= 1'b0;
            rom_addr_q   <= '0;
            pipe_q       <= '{default: '0};
            out_q        <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            act_q        <= act_d;
            vblnk_prev_q <= vblnk_prev_d;
            frame_upd_q  <= frame_upd_d;
            rom_addr_q   <= rom_addr_d;
            pipe_q       <= pipe_d;
            out_q        <= out_d;
        end
    end

    assign vga_out.vcount = out_q.vcount;
    assign vga_out.hcount = out_q.hcount;
    assign vga_out.vsync  = out_q.vsync;
    assign vga_out.hsync  = out_q.hsync;
    assign vga_out.vblnk  = out_q.vblnk;
    assign vga_out.hblnk  = out_q.hblnk;
    assign vga_out.rgb    = out_q.rgb;
    assign rom_addr       = rom_addr_q;
    assign frame_upd      = frame_upd_q;
endmodule

// File: tb/tb_draw_sprite_pipe.sv
// Randomised bench for draw_sprite_pipe: two instances (ROM_LAT 1 keyed,
// ROM_LAT 3 unkeyed) against a pixel-level reference model.
module tb_draw_sprite_pipe;
    localparam int W  = 100;
    localparam int H  = 100;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_if vin ();
    vga_if vo_a ();
    vga_if vo_b ();

    logic [11:0]   xpos, ypos;
    logic          mirror_x, sprite_en, pos_valid;
    logic [AW-1:0] addr_a, addr_b;
    logic [11:0]   pix_a, pix_b;
    logic          fu_a, fu_b;
    logic [AW-1:0] rb1, rb2;

    draw_sprite_pipe #(.W(W), .H(H), .ADDR_W(AW), .ROM_LAT(1), .KEY_EN(1'b1),
                       .KEY_COLOR(12'hF0F)) u_a (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vo_a),
        .xpos(xpos), .ypos(ypos), .mirror_x(mirror_x), .sprite_en(sprite_en),
        .pos_valid(pos_valid), .rom_addr(addr_a), .rom_pixel(pix_a),
        .frame_upd(fu_a)
    );

    draw_sprite_pipe #(.W(W), .H(H), .ADDR_W(AW), .ROM_LAT(3), .KEY_EN(1'b0),
                       .KEY_COLOR(12'hF0F)) u_b (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vo_b),
        .xpos(xpos), .ypos(ypos), .mirror_x(mirror_x), .sprite_en(sprite_en),
        .pos_valid(pos_valid), .rom_addr(addr_b), .rom_pixel(pix_b),
        .frame_upd(fu_b)
    );

    function automatic logic [11:0] rom_f(input logic [AW-1:0] a);
        int ai;
        logic [11:0] r;
        ai = int'(a);
        if (ai % 37 == 5) return 12'hF0F;
        r = 12'((ai * 13 + 291) % 4096);
        return (r == 12'hF0F) ? 12'h000 : r;
    endfunction

    // ROM of latency 1 reads straight off the registered address.
    assign pix_a = rom_f(addr_a);
    always_ff @(posedge clk) begin
        rb1 <= addr_b;
        rb2 <= rb1;
    end
    assign pix_b = rom_f(rb2);

    int n_chk = 0;
    int n_err = 0;
    int n = 0;

    logic [27:0]   e_tim   [16];
    logic [11:0]   e_rgb_a [16];
    logic [11:0]   e_rgb_b [16];
    logic [AW-1:0] e_addr  [16];
    bit            e_fu    [16];
    bit            e_ok    [16];

    bit m_pend, m_ae, m_am, m_pm, m_pe, prev_vb;
    int m_ax, m_ay, m_px, m_py;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_tim_a"}, 32'({vo_a.vcount, vo_a.hcount, vo_a.vsync,
              vo_a.hsync, vo_a.vblnk, vo_a.hblnk}), 32'd0);
        check({tag, "_rgb_a"}, 32'(vo_a.rgb), 32'd0);
        check({tag, "_tim_b"}, 32'({vo_b.vcount, vo_b.hcount, vo_b.vsync,
              vo_b.hsync, vo_b.vblnk, vo_b.hblnk}), 32'd0);
        check({tag, "_rgb_b"}, 32'(vo_b.rgb), 32'd0);
        check({tag, "_addr_a"}, 32'(addr_a), 32'd0);
        check({tag, "_addr_b"}, 32'(addr_b), 32'd0);
        check({tag, "_fu_a"}, 32'(fu_a), 32'd0);
        check({tag, "_fu_b"}, 32'(fu_b), 32'd0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) e_ok[i] = 1'b0;
        m_pend = 0; m_ae = 0; m_am = 0; m_pm = 0; m_pe = 0; prev_vb = 0;
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
    endtask

    task automatic step(input int h, input int v, input bit hb, input bit vbl,
                        input bit pv, input int px, input int py,
                        input bit pm, input bit pe);
        bit hit, upd, hs, vs;
        int col, a, k;
        logic [11:0] rgb, p;
        @(negedge clk);
        if (n >= 2 && e_ok[(n-2)%16]) begin
            k = (n - 2) % 16;
            check("tim_a", 32'({vo_a.vcount, vo_a.hcount, vo_a.vsync,
                  vo_a.hsync, vo_a.vblnk, vo_a.hblnk}), 32'(e_tim[k]));
            check("rgb_a", 32'(vo_a.rgb), 32'(e_rgb_a[k]));
        end
        if (n >= 4 && e_ok[(n-4)%16]) begin
            k = (n - 4) % 16;
            check("tim_b", 32'({vo_b.vcount, vo_b.hcount, vo_b.vsync,
                  vo_b.hsync, vo_b.vblnk, vo_b.hblnk}), 32'(e_tim[k]));
            check("rgb_b", 32'(vo_b.rgb), 32'(e_rgb_b[k]));
        end
        if (n >= 1 && e_ok[(n-1)%16]) begin
            k = (n - 1) % 16;
            check("addr_a", 32'(addr_a), 32'(e_addr[k]));
            check("addr_b", 32'(addr_b), 32'(e_addr[k]));
            check("fu_a", 32'(fu_a), 32'(e_fu[k]));
            check("fu_b", 32'(fu_b), 32'(e_fu[k]));
        end
        rgb = 12'($urandom);
        hs  = 1'($urandom);
        vs  = 1'($urandom);
        vin.hcount = 12'(h);
        vin.vcount = 12'(v);
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vbl;
        vin.rgb    = rgb;
        pos_valid  = pv;
        xpos       = 12'(px);
        ypos       = 12'(py);
        mirror_x   = pm;
        sprite_en  = pe;
        hit = m_ae && h >= m_ax && h < m_ax + W && v >= m_ay && v < m_ay + H;
        col = m_am ? (W - 1 - (h - m_ax)) : (h - m_ax);
        a   = hit ? (v - m_ay) * W + col : 0;
        p   = rom_f(AW'(a));
        k   = n % 16;
        e_tim[k]   = {12'(v), 12'(h), vs, hs, vbl, hb};
        e_addr[k]  = AW'(a);
        e_rgb_a[k] = (hit && !(hb || vbl) && p != 12'hF0F) ? p : rgb;
        e_rgb_b[k] = (hit && !(hb || vbl)) ? p : rgb;
        upd = vbl && !prev_vb && (pv || m_pend);
        e_fu[k] = upd;
        e_ok[k] = 1'b1;
        if (upd) begin
            if (pv) begin
                m_ax = px; m_ay = py; m_am = pm; m_ae = pe;
            end else begin
                m_ax = m_px; m_ay = m_py; m_am = m_pm; m_ae = m_pe;
            end
            m_pend = 0;
        end else if (pv) begin
            m_px = px; m_py = py; m_pm = pm; m_pe = pe; m_pend = 1;
        end
        prev_vb = vbl;
        n++;
    endtask

    task automatic pix(input int h, input int v);
        step(h, v, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd(input int cnt, input int cx, input int cy);
        int h, v;
        for (int i = 0; i < cnt; i++) begin
            if ($urandom % 4 != 0) begin
                h = (cx - 4 + int'($urandom_range(0, W + 7))) & 4095;
                v = (cy - 4 + int'($urandom_range(0, H + 7))) & 4095;
            end else begin
                h = int'($urandom % 4096);
                v = int'($urandom % 4096);
            end
            step(h, v, ($urandom % 8 == 0), 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic strobe(input int px, input int py, input bit pm, input bit pe);
        step(int'($urandom % 4096), int'($urandom % 4096), 0, 0, 1, px, py, pm, pe);
    endtask

    task automatic vblank(input bit pv, input int px, input int py,
                          input bit pm, input bit pe);
        step(int'($urandom % 4096), int'($urandom % 4096), 1, 1, pv, px, py, pm, pe);
        repeat (3) step(int'($urandom % 4096), int'($urandom % 4096), 1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        int px, py;
        bit pm, pe;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
        vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0;
        xpos = '0; ypos = '0; mirror_x = 0; sprite_en = 0; pos_valid = 0;
        model_clear();
        #1 rst = 1'b1;
        #1 chk_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        rnd(200, 200, 100);
        strobe(200, 100, 0, 1);
        rnd(100, 200, 100);
        pix(200, 100);
        vblank(0, 0, 0, 0, 0);
        pix(200, 100); pix(299, 199); pix(300, 100); pix(200, 200);
        pix(205, 100); pix(199, 150); pix(250, 99);
        rnd(300, 200, 100);

        strobe(7, 9, 0, 1);
        rnd(20, 7, 9);
        strobe(0, 0, 1, 1);
        rnd(50, 0, 0);
        vblank(0, 0, 0, 0, 0);
        pix(0, 0); pix(99, 0); pix(94, 0); pix(99, 99); pix(100, 0);
        rnd(250, 0, 0);

        vblank(0, 0, 0, 0, 0);
        rnd(40, 0, 0);

        strobe(4050, 0, 0, 1);
        vblank(0, 0, 0, 0, 0);
        pix(4050, 0); pix(4095, 0); pix(4049, 0); pix(4095, 99);
        for (int h = 0; h < 60; h++) pix(h, 5);
        rnd(200, 4050, 0);

        vblank(1, 1000, 500, 1, 1);
        pix(1000, 500); pix(1099, 599); pix(1100, 500);
        rnd(200, 1000, 500);
        do_reset();
        rnd(150, 1000, 500);

        for (int it = 0; it < 15; it++) begin
            px = int'($urandom_range(0, 4095));
            py = int'($urandom_range(0, 4095));
            pm = 1'($urandom);
            pe = ($urandom % 4 != 0);
            if ($urandom % 2 == 0) strobe(px, py, pm, pe);
            rnd(60, m_ax, m_ay);
            px = int'($urandom_range(0, 600));
            py = int'($urandom_range(0, 400));
            pm = 1'($urandom);
            vblank(($urandom % 3 == 0), px, py, pm, 1'b1);
            rnd(120, m_ax, m_ay);
        end
        rnd(8, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
